// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts DATA_W-bit words over valid/ready and shifts them
// out one registered bit per clock, with optional idle gap bits between words.
module bit_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic        IDLE_BIT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              din_bit,
  output logic              bit_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned     CntW        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastCnt     = CntW'(DATA_W - 1);
  localparam logic [7:0]      GapLoad     = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit              BackToBack  = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [7:0]        gap_cnt_q;

  logic              load_bit;
  logic [DATA_W-1:0] load_rest;
  logic              next_bit;
  logic [DATA_W-1:0] next_rest;
  logic              last_bit;
  logic              accept;

  // shift_q holds only the bits not yet presented on din_bit.
  always_comb begin
    if (MSB_FIRST) begin
      load_bit  = in_data[DATA_W-1];
      load_rest = in_data << 1;
      next_bit  = shift_q[DATA_W-1];
      next_rest = shift_q << 1;
    end else begin
      load_bit  = in_data[0];
      load_rest = in_data >> 1;
      next_bit  = shift_q[0];
      next_rest = shift_q >> 1;
    end
  end

  assign last_bit = (state_q == StShift) && (bit_cnt_q == LastCnt);
  assign in_ready = rst && ((state_q == StIdle) || (last_bit && BackToBack));
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      din_bit     <= IDLE_BIT;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      // accept can only be true in IDLE or on a back-to-back last bit.
      if (accept) begin
        state_q     <= StShift;
        din_bit     <= load_bit;
        shift_q     <= load_rest;
        bit_cnt_q   <= '0;
        bit_valid   <= 1'b1;
        frame_start <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            din_bit   <= IDLE_BIT;
            bit_valid <= 1'b0;
          end
          StShift: begin
            if (!last_bit) begin
              din_bit    <= next_bit;
              shift_q    <= next_rest;
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              frame_done <= (bit_cnt_q == LastCnt - 1'b1);
            end else if (!BackToBack) begin
              state_q   <= StGap;
              gap_cnt_q <= GapLoad;
              din_bit   <= IDLE_BIT;
              bit_valid <= 1'b0;
            end else begin
              state_q   <= StIdle;
              din_bit   <= IDLE_BIT;
              bit_valid <= 1'b0;
            end
          end
          StGap: begin
            if (gap_cnt_q == 8'd0) begin
              state_q <= StIdle;
            end else begin
              gap_cnt_q <= gap_cnt_q - 8'd1;
            end
          end
          default: begin
            state_q   <= StIdle;
            din_bit   <= IDLE_BIT;
            bit_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
